buck_pwm_gen: RTL and testbench

- Digital PWM gate-drive generator that produces the `gate` signal for the buck converter emulation model.
- Replaces the fixed-duty PWM macro with a block whose duty and period are programmable at runtime, so a closed-loop controller or host can change them.
- Provides soft-start ramping, glitch-free updates applied only at period boundaries, and a minimum off-time clamp.
- Runs on the emulator clock: one clk cycle equals one emulation time step.

---
 rtl/buck_pwm_gen.sv | 120 ++++++++++++
 tb/tb_buck_pwm_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/buck_pwm_gen.sv
// PWM gate generator for the buck emulation model. Period and duty are programmable,
// with soft-start ramping, updates only at period boundaries, and a minimum off-time clamp.
module buck_pwm_gen #(
  parameter int CNT_W      = 16,
  parameter int PERIOD_RST = 200,
  parameter int DUTY_RST   = 100,
  parameter int SS_STEP    = 4,
  parameter int MIN_OFF    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  output logic             gate,
  output logic             cyc_start,
  output logic             ss_done
);

  typedef enum logic [1:0] {IDLE, SOFT, RUN} state_e;

  localparam logic [CNT_W-1:0] PER_R   = CNT_W'(PERIOD_RST);
  localparam logic [CNT_W-1:0] DUTY_R  = CNT_W'(DUTY_RST);
  localparam logic [CNT_W-1:0] MOFF    = CNT_W'(MIN_OFF);
  localparam logic [CNT_W-1:0] PER_MIN = CNT_W'(2);
  localparam logic [CNT_W:0]   STEP    = (CNT_W+1)'(SS_STEP);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, eff_q, eff_d;
  logic [CNT_W-1:0] period_q, period_d, target_q, target_d;
  logic [CNT_W-1:0] sh_per_q, sh_per_d, sh_duty_q, sh_duty_d;
  logic             pending_q, pending_d;
  logic             gate_d, cyc_d, ss_d;

  logic [CNT_W-1:0] per_clamp, lim, duty_clamp, ramp_min;
  logic [CNT_W:0]   ramp;
  logic             boundary, apply, xfer;

  assign cfg_ready = !pending_q;

  always_comb begin
    per_clamp  = (cfg_period < PER_MIN) ? PER_MIN : cfg_period;
    lim        = (per_clamp >= MOFF) ? per_clamp - MOFF : '0;
    duty_clamp = (cfg_duty < lim) ? cfg_duty : lim;
  end

  assign boundary = (state_q != IDLE) && (cnt_q == period_q - 1'b1);
  assign apply    = pending_q && (boundary || state_q == IDLE);
  // Transfers only happen with nothing pending, so a boundary copy always
  // uses the shadow captured before this cycle.
  assign xfer     = cfg_valid && !pending_q;

  always_comb begin
    period_d  = apply ? sh_per_q  : period_q;
    target_d  = apply ? sh_duty_q : target_q;
    pending_d = xfer ? 1'b1 : (apply ? 1'b0 : pending_q);
    sh_per_d  = xfer ? per_clamp  : sh_per_q;
    sh_duty_d = xfer ? duty_clamp : sh_duty_q;

    ramp     = {1'b0, eff_q} + STEP;
    ramp_min = (ramp < {1'b0, target_d}) ? ramp[CNT_W-1:0] : target_d;

    state_d = state_q;
    cnt_d   = boundary ? '0 : cnt_q + 1'b1;
    eff_d   = eff_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        eff_d = '0;
        if (en) state_d = SOFT;
      end
      SOFT: if (boundary) begin
        eff_d = ramp_min;
        if (ramp_min == target_d) state_d = RUN;
      end
      RUN: if (boundary) eff_d = target_d;
      default: state_d = IDLE;
    endcase
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      eff_d   = '0;
    end

    gate_d = (state_d != IDLE) && (cnt_d < eff_d);
    cyc_d  = (state_d != IDLE) && (cnt_d == '0);
    ss_d   = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      eff_q     <= '0;
      period_q  <= PER_R;
      target_q  <= DUTY_R;
      sh_per_q  <= PER_R;
      sh_duty_q <= DUTY_R;
      pending_q <= 1'b0;
      gate      <= 1'b0;
      cyc_start <= 1'b0;
      ss_done   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      eff_q     <= eff_d;
      period_q  <= period_d;
      target_q  <= target_d;
      sh_per_q  <= sh_per_d;
      sh_duty_q <= sh_duty_d;
      pending_q <= pending_d;
      gate      <= gate_d;
      cyc_start <= cyc_d;
      ss_done   <= ss_d;
    end
  end

endmodule

// File: tb/tb_buck_pwm_gen.sv
// Directed bench for buck_pwm_gen: ramp, reconfiguration, clamps, enable drop,
// async reset and config offered on the wrap cycle.
module tb_buck_pwm_gen;
  localparam int CNT_W = 16;
  localparam int BOUND = 1000;

  logic             clk = 0, rst = 0, en = 0, cfg_valid = 0;
  logic             cfg_ready, gate, cyc_start, ss_done;
  logic [CNT_W-1:0] cfg_period = '0, cfg_duty = '0;

  int checks = 0, errors = 0;

  buck_pwm_gen #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .gate(gate), .cyc_start(cyc_start), .ss_done(ss_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Count cycles and gate-high cycles from the current negedge up to the next cyc_start.
  task automatic count_to_next(output int len, output int high);
    len = 0; high = 0;
    do begin
      high += int'(gate); len++;
      @(negedge clk);
    end while (!cyc_start && len < BOUND);
    if (len >= BOUND) begin
      checks++; errors++;
      $display("FAIL count_timeout: no cyc_start within %0d cycles", BOUND);
    end
  endtask

  // Measure one full period starting at the next (or current) cyc_start.
  task automatic measure(output int len, output int high, output logic ssd);
    int n = 0;
    while (!cyc_start && n < BOUND) begin @(negedge clk); n++; end
    if (n >= BOUND) begin
      checks++; errors++;
      $display("FAIL wait_timeout: no cyc_start within %0d cycles", BOUND);
    end
    ssd = ss_done;
    count_to_next(len, high);
  endtask

  task automatic send_cfg(input int per, input int duty);
    cfg_period = CNT_W'(per); cfg_duty = CNT_W'(duty); cfg_valid = 1;
    @(negedge clk);
    cfg_valid = 0;
  endtask

  task automatic test_reset;
    rst = 0; en = 0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (gate !== 1'b0)      begin errors++; $display("FAIL rst_gate got %b want 0", gate); end
    if (cyc_start !== 1'b0) begin errors++; $display("FAIL rst_cyc got %b want 0", cyc_start); end
    if (ss_done !== 1'b0)   begin errors++; $display("FAIL rst_ssd got %b want 0", ss_done); end
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", cfg_ready); end
    rst = 1;
    @(negedge clk);
  endtask

  task automatic test_softstart;
    int len, high; logic ssd;
    en = 1;
    for (int k = 0; k <= 25; k++) begin
      measure(len, high, ssd);
      checks += 3;
      if (len != 200)      begin errors++; $display("FAIL ramp_len k=%0d got %0d want 200", k, len); end
      if (high != 4*k)     begin errors++; $display("FAIL ramp_high k=%0d got %0d want %0d", k, high, 4*k); end
      if (ssd !== (k == 25)) begin errors++; $display("FAIL ramp_ssd k=%0d got %b want %b", k, ssd, k == 25); end
    end
  endtask

  task automatic test_cfg_midperiod;
    int len, high = 0, pulses = 0; logic ssd;
    for (int i = 0; i < 200; i++) begin
      high += int'(gate);
      if (i > 0) pulses += int'(cyc_start);
      if (i == 50) begin cfg_period = 100; cfg_duty = 30; cfg_valid = 1; end
      if (i == 51) begin
        cfg_valid = 0; checks++;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_after_xfer got %b want 0", cfg_ready); end
      end
      if (i == 199) begin
        checks++;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_at_wrap got %b want 0", cfg_ready); end
      end
      @(negedge clk);
    end
    checks += 4;
    if (high != 100)        begin errors++; $display("FAIL mid_old_high got %0d want 100", high); end
    if (pulses != 0)        begin errors++; $display("FAIL mid_early_wrap got %0d want 0", pulses); end
    if (cyc_start !== 1'b1) begin errors++; $display("FAIL mid_wrap_cyc got %b want 1", cyc_start); end
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after got %b want 1", cfg_ready); end
    measure(len, high, ssd);
    checks += 2;
    if (len != 100) begin errors++; $display("FAIL mid_new_len got %0d want 100", len); end
    if (high != 30) begin errors++; $display("FAIL mid_new_high got %0d want 30", high); end
  endtask

  task automatic test_clamp;
    int len, high; logic ssd;
    send_cfg(200, 250);
    measure(len, high, ssd);
    checks += 2;
    if (len != 200) begin errors++; $display("FAIL clamp_duty_len got %0d want 200", len); end
    if (high != 198) begin errors++; $display("FAIL clamp_duty_high got %0d want 198", high); end
    send_cfg(1, 5);
    for (int k = 0; k < 2; k++) begin
      measure(len, high, ssd);
      checks += 3;
      if (len != 2)  begin errors++; $display("FAIL clamp_per_len k=%0d got %0d want 2", k, len); end
      if (high != 0) begin errors++; $display("FAIL clamp_per_high k=%0d got %0d want 0", k, high); end
      if (ssd !== 1'b1) begin errors++; $display("FAIL clamp_per_ssd k=%0d got %b want 1", k, ssd); end
    end
    // Zero target from IDLE still reaches RUN after one period.
    en = 0;
    @(negedge clk);
    en = 1;
    measure(len, high, ssd);
    checks += 2;
    if (ssd !== 1'b0) begin errors++; $display("FAIL zero_soft_ssd got %b want 0", ssd); end
    if (high != 0)    begin errors++; $display("FAIL zero_soft_high got %0d want 0", high); end
    measure(len, high, ssd);
    checks++;
    if (ssd !== 1'b1) begin errors++; $display("FAIL zero_run_ssd got %b want 1", ssd); end
    send_cfg(200, 100);
    measure(len, high, ssd);
    checks += 2;
    if (len != 200)  begin errors++; $display("FAIL restore_len got %0d want 200", len); end
    if (high != 100) begin errors++; $display("FAIL restore_high got %0d want 100", high); end
  endtask

  task automatic test_en_drop;
    int len, high, stray = 0; logic ssd;
    repeat (50) @(negedge clk);
    checks += 2;
    if (gate !== 1'b1)    begin errors++; $display("FAIL drop_pre_gate got %b want 1", gate); end
    if (ss_done !== 1'b1) begin errors++; $display("FAIL drop_pre_ssd got %b want 1", ss_done); end
    en = 0;
    @(negedge clk);
    checks += 2;
    if (gate !== 1'b0)    begin errors++; $display("FAIL drop_gate got %b want 0", gate); end
    if (ss_done !== 1'b0) begin errors++; $display("FAIL drop_ssd got %b want 0", ss_done); end
    repeat (5) begin @(negedge clk); stray += int'(gate) + int'(cyc_start); end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL idle_activity got %0d want 0", stray); end
    en = 1;
    measure(len, high, ssd);
    checks += 3;
    if (ssd !== 1'b0) begin errors++; $display("FAIL reen_ssd got %b want 0", ssd); end
    if (high != 0)    begin errors++; $display("FAIL reen_high0 got %0d want 0", high); end
    if (len != 200)   begin errors++; $display("FAIL reen_len got %0d want 200", len); end
    measure(len, high, ssd);
    checks++;
    if (high != 4) begin errors++; $display("FAIL reen_high1 got %0d want 4", high); end
  endtask

  task automatic test_reset_mid_soft;
    int len, high, stray = 0; logic ssd;
    send_cfg(120, 60);
    checks++;
    if (gate !== 1'b1) begin errors++; $display("FAIL soft_gate8 got %b want 1", gate); end
    measure(len, high, ssd);
    checks += 2;
    if (len != 120) begin errors++; $display("FAIL soft_newper_len got %0d want 120", len); end
    if (high != 12) begin errors++; $display("FAIL soft_newper_high got %0d want 12", high); end
    @(negedge clk);
    checks++;
    if (gate !== 1'b1) begin errors++; $display("FAIL soft_gate16 got %b want 1", gate); end
    #2 rst = 0; en = 0;
    #1;
    checks += 4;
    if (gate !== 1'b0)      begin errors++; $display("FAIL arst_gate got %b want 0", gate); end
    if (cyc_start !== 1'b0) begin errors++; $display("FAIL arst_cyc got %b want 0", cyc_start); end
    if (ss_done !== 1'b0)   begin errors++; $display("FAIL arst_ssd got %b want 0", ss_done); end
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %b want 1", cfg_ready); end
    @(negedge clk);
    rst = 1;
    repeat (3) begin @(negedge clk); stray += int'(gate) + int'(cyc_start); end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL arst_idle got %0d want 0", stray); end
  endtask

  task automatic test_back_to_back;
    int len, high, h0; logic ssd;
    send_cfg(150, 50);
    repeat (198) @(negedge clk);
    checks += 2;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL b2b_pending got %b want 0", cfg_ready); end
    if (cyc_start !== 1'b0) begin errors++; $display("FAIL b2b_prewrap_cyc got %b want 0", cyc_start); end
    cfg_period = 80; cfg_duty = 20; cfg_valid = 1;
    @(negedge clk);
    checks += 2;
    if (cyc_start !== 1'b1) begin errors++; $display("FAIL b2b_wrap_cyc got %b want 1", cyc_start); end
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after got %b want 1", cfg_ready); end
    h0 = int'(gate);
    @(negedge clk);
    cfg_valid = 0;
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_xfer got %b want 0", cfg_ready); end
    count_to_next(len, high);
    checks += 3;
    if (len + 1 != 150)  begin errors++; $display("FAIL b2b_old_len got %0d want 150", len + 1); end
    if (high + h0 != 50) begin errors++; $display("FAIL b2b_old_high got %0d want 50", high + h0); end
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_final got %b want 1", cfg_ready); end
    measure(len, high, ssd);
    checks += 2;
    if (len != 80)  begin errors++; $display("FAIL b2b_new_len got %0d want 80", len); end
    if (high != 20) begin errors++; $display("FAIL b2b_new_high got %0d want 20", high); end
  endtask

  initial begin
    test_reset;
    test_softstart;
    test_cfg_midperiod;
    test_clamp;
    test_en_drop;
    test_reset_mid_soft;
    test_softstart;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
